hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/riscv_pkg.sv | 17 +
 rtl/hazard_fwd_sel.sv | 23 ++
 rtl/hazard_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types and encodings for the pipeline hazard logic: memory-wait FSM
// states, ALU operand forwarding selects and the load result-select code.
package riscv_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    WAIT  = 2'b01,
    FAULT = 2'b10
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forwarding select for one Execute-stage source register.
// The Memory stage holds the younger write, so it wins over Writeback.
module hazard_fwd_sel
  import riscv_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      fwd = FWD_MEM;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use stall, branch flush, memory-wait
// freeze with timeout fault, and saturating stall/flush performance counters.
module hazard_unit
  import riscv_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic             MemFault
);

  // One spare bit so the incremented wait count never wraps before the compare.
  localparam int WCNT_W = $clog2(MAX_WAIT + 2);
  localparam logic [WCNT_W-1:0] MAX_WAIT_V = WCNT_W'(MAX_WAIT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  hz_state_e         state, state_nxt;
  logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt, wait_inc;
  logic [1:0]        fwd_a, fwd_b;
  logic              lw_stall, mem_busy, freeze;

  hazard_fwd_sel u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_a)
  );

  hazard_fwd_sel u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_b)
  );

  assign lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_busy = MemReqM && !MemReadyM;
  assign freeze   = mem_busy || (state == FAULT);
  assign MemFault = (state == FAULT);
  assign wait_inc = wait_cnt + WCNT_W'(1);

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = fwd_a;
    ForwardBE = fwd_b;
    if (RST) begin
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
    end else if (freeze) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else begin
      // A taken branch discards the load-use consumer, so no stall is needed.
      StallF = lw_stall && !PCSrcE;
      StallD = lw_stall && !PCSrcE;
      FlushD = PCSrcE;
      FlushE = lw_stall || PCSrcE;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      RUN: begin
        if (mem_busy) begin
          state_nxt    = WAIT;
          wait_cnt_nxt = WCNT_W'(1);
        end
      end
      WAIT: begin
        if (MemReadyM) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_inc;
          if (wait_inc >= MAX_WAIT_V) state_nxt = FAULT;
        end
      end
      FAULT: state_nxt = FAULT;
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= RUN;
      wait_cnt <= '0;
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (StallF) StallCnt <= sat_inc(StallCnt);
      if (FlushD) FlushCnt <= sat_inc(FlushCnt);
    end
  end

endmodule
